fp_add_v1_normalize_shift: RTL and testbench

Pipelined post-add normalizer for the fp_add_v1 datapath. It receives the leading-zero count and zero flag produced by the altpriority encoder tree, together with the raw sum mantissa and exponent. It left-shifts the mantissa so the MSB becomes 1 and decrements the exponent by the same amount. Denormal and zero results are clamped per IEEE-754. It sits between the priority-encoder stage and the rounding stage, with a valid/ready handshake on both sides.

---
 rtl/fp_add_v1_pkg.sv | 33 +++
 rtl/fp_add_v1_lshift_stage.sv | 15 +
 rtl/fp_add_v1_normalize_shift.sv | 139 +++++++++++++
 tb/tb_fp_add_v1_normalize_shift.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_v1_pkg.sv
// Shared constants, helpers and stage payload types for the fp_add_v1 normalizer.
package fp_add_v1_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_WIDTH_MAN = 26;
  localparam int unsigned DEF_WIDTH_CNT = clog2(DEF_WIDTH_MAN);
  localparam int unsigned DEF_WIDTH_EXP = 8;

  // Low bits of the shift amount left for the second (fine) shifter.
  localparam int unsigned FINE_W = (DEF_WIDTH_CNT + 1) / 2;

  localparam logic [DEF_WIDTH_EXP-1:0] EXP_ZERO = '0;

  typedef struct packed {
    logic [DEF_WIDTH_MAN-1:0] man;
    logic [DEF_WIDTH_EXP-1:0] exp;
    logic [FINE_W-1:0]        fine_shift;
    logic                     denorm;
    logic                     zero;
  } stage1_t;

endpackage

// File: rtl/fp_add_v1_lshift_stage.sv
// Combinational zero-filling left shifter; used for both coarse and fine steps.
module fp_add_v1_lshift_stage #(
  parameter int unsigned WIDTH   = 26,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHIFT_W-1:0] amount,
  output logic [WIDTH-1:0]   shifted_c
);

  always_comb begin
    shifted_c = data << amount;
  end

endmodule

// File: rtl/fp_add_v1_normalize_shift.sv
// Two-stage post-add normalizer: clamps the leading-zero count against the exponent,
// left-shifts the mantissa (coarse then fine) and adjusts the exponent.
module fp_add_v1_normalize_shift
  import fp_add_v1_pkg::*;
#(
  parameter int unsigned WIDTH_MAN = DEF_WIDTH_MAN,
  parameter int unsigned WIDTH_CNT = DEF_WIDTH_CNT,
  parameter int unsigned WIDTH_EXP = DEF_WIDTH_EXP
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 clk_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_MAN-1:0] in_man,
  input  logic [WIDTH_EXP-1:0] in_exp,
  input  logic [WIDTH_CNT-1:0] in_q,
  input  logic                 in_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_MAN-1:0] out_man,
  output logic [WIDTH_EXP-1:0] out_exp,
  output logic                 out_denorm,
  output logic                 out_zero
);

  localparam int unsigned CMP_W = (WIDTH_EXP > WIDTH_CNT) ? WIDTH_EXP : WIDTH_CNT;
  localparam logic [WIDTH_CNT-1:0] Q_MAX     = WIDTH_CNT'(WIDTH_MAN - 1);
  localparam logic [WIDTH_CNT-1:0] FINE_MASK = WIDTH_CNT'((1 << FINE_W) - 1);

  logic                 advance;
  logic [WIDTH_CNT-1:0] q_c;
  logic [CMP_W-1:0]     q_ext;
  logic [CMP_W-1:0]     exp_ext;
  logic [WIDTH_CNT-1:0] shift;
  logic [WIDTH_CNT-1:0] coarse_shift;
  logic [WIDTH_EXP-1:0] exp_res;
  logic                 denorm;
  logic                 zero;
  logic [WIDTH_MAN-1:0] man_sel;
  logic [WIDTH_MAN-1:0] coarse_man;
  logic [WIDTH_MAN-1:0] fine_man;
  stage1_t              s1_d;
  stage1_t              s1_q;
  logic                 s1_valid;

  // Whole pipeline moves together whenever the output slot can be refilled.
  always_comb begin
    advance  = clk_en & ~sclr & (~out_valid | out_ready);
    in_ready = advance;
  end

  // Shift amount and exponent adjustment; the shift never drives the exponent below 1.
  always_comb begin
    q_c     = (in_q > Q_MAX) ? Q_MAX : in_q;
    q_ext   = CMP_W'(q_c);
    exp_ext = CMP_W'(in_exp);
    shift   = '0;
    exp_res = EXP_ZERO;
    denorm  = 1'b0;
    zero    = 1'b0;
    if (in_zero) begin
      zero = 1'b1;
    end else if (in_exp == EXP_ZERO) begin
      denorm = 1'b1;
    end else if (q_ext < exp_ext) begin
      shift   = q_c;
      exp_res = WIDTH_EXP'(exp_ext - q_ext);
    end else begin
      shift  = WIDTH_CNT'(exp_ext - CMP_W'(1));
      denorm = 1'b1;
    end
  end

  always_comb begin
    coarse_shift = shift & ~FINE_MASK;
    man_sel      = in_zero ? '0 : in_man;
  end

  fp_add_v1_lshift_stage #(
    .WIDTH   (WIDTH_MAN),
    .SHIFT_W (WIDTH_CNT)
  ) u_coarse (
    .data      (man_sel),
    .amount    (coarse_shift),
    .shifted_c (coarse_man)
  );

  always_comb begin
    s1_d            = '0;
    s1_d.man        = coarse_man;
    s1_d.exp        = exp_res;
    s1_d.fine_shift = FINE_W'(shift);
    s1_d.denorm     = denorm;
    s1_d.zero       = zero;
  end

  // Stage 1 register.
  always_ff @(posedge clock) begin
    if (sclr) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  fp_add_v1_lshift_stage #(
    .WIDTH   (WIDTH_MAN),
    .SHIFT_W (FINE_W)
  ) u_fine (
    .data      (s1_q.man),
    .amount    (s1_q.fine_shift),
    .shifted_c (fine_man)
  );

  // Stage 2 / output register.
  always_ff @(posedge clock) begin
    if (sclr) begin
      out_valid  <= 1'b0;
      out_man    <= '0;
      out_exp    <= '0;
      out_denorm <= 1'b0;
      out_zero   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_man    <= fine_man;
        out_exp    <= s1_q.exp;
        out_denorm <= s1_q.denorm;
        out_zero   <= s1_q.zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_v1_normalize_shift.sv
// Self-checking bench for fp_add_v1_normalize_shift: directed cases, backpressure,
// clock-enable gating, mid-stream reset and randomized traffic against a reference model.
module tb_fp_add_v1_normalize_shift;

  localparam int unsigned MW = 26;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = 5;

  typedef struct packed {
    logic [MW-1:0] man;
    logic [EW-1:0] exp;
    logic          den;
    logic          zero;
  } res_t;

  logic          clock = 1'b0;
  logic          sclr;
  logic          clk_en;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_man;
  logic [EW-1:0] in_exp;
  logic [CW-1:0] in_q;
  logic          in_zero;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_man;
  logic [EW-1:0] out_exp;
  logic          out_denorm;
  logic          out_zero;

  always #5 clock = ~clock;

  fp_add_v1_normalize_shift #(
    .WIDTH_MAN (MW),
    .WIDTH_CNT (CW),
    .WIDTH_EXP (EW)
  ) dut (
    .clock      (clock),
    .sclr       (sclr),
    .clk_en     (clk_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_man     (in_man),
    .in_exp     (in_exp),
    .in_q       (in_q),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_man    (out_man),
    .out_exp    (out_exp),
    .out_denorm (out_denorm),
    .out_zero   (out_zero)
  );

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  res_t exp_q[$];
  res_t mon_exp;
  res_t prev_out;
  bit   prev_stall = 1'b0;
  int   ce_cyc[6];
  int   ce_ref[6];
  logic [MW-1:0] beat_man[6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: normalise with plain integer arithmetic.
  function automatic res_t model(input logic [MW-1:0] man, input logic [EW-1:0] e,
                                 input logic [CW-1:0] q, input logic z);
    res_t r;
    int qc;
    int ei;
    int sh;
    logic [63:0] m;
    r  = '0;
    qc = (int'(q) > int'(MW) - 1) ? int'(MW) - 1 : int'(q);
    ei = int'(e);
    sh = 0;
    if (z) begin
      r.zero = 1'b1;
      return r;
    end
    if (ei == 0) begin
      r.den = 1'b1;
    end else if (qc < ei) begin
      sh    = qc;
      r.exp = EW'(ei - qc);
    end else begin
      sh    = ei - 1;
      r.den = 1'b1;
    end
    m     = 64'(man) << sh;
    r.man = m[MW-1:0];
    return r;
  endfunction

  // Scoreboard, handshake rule and stall-stability monitor.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(clk_en & ~sclr & (~out_valid | out_ready)));
      if (prev_stall)
        chk("stall_hold", 64'({out_valid, out_man, out_exp, out_denorm, out_zero}),
            64'({1'b1, prev_out}));
      if (out_valid && out_ready && clk_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          chk("result", 64'({out_man, out_exp, out_denorm, out_zero}), 64'(mon_exp));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_man, in_exp, in_q, in_zero));
      if (sclr) exp_q.delete();
      prev_stall = out_valid & ~out_ready & ~sclr;
      prev_out   = {out_man, out_exp, out_denorm, out_zero};
    end
  end

  task automatic drive(input logic [MW-1:0] man, input logic [EW-1:0] e,
                       input logic [CW-1:0] q, input logic z);
    in_man   = man;
    in_exp   = e;
    in_q     = q;
    in_zero  = z;
    in_valid = 1'b1;
  endtask

  // Present one beat with an empty pipeline and check it exactly two edges after transfer.
  task automatic directed(input string tag, input logic [MW-1:0] man, input logic [EW-1:0] e,
                          input logic [CW-1:0] q, input logic z, input logic [MW-1:0] x_man,
                          input logic [EW-1:0] x_exp, input logic x_den, input logic x_zero);
    int n;
    @(posedge clock); #1;
    drive(man, e, q, z);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 50) chk({tag, "_accept_timeout"}, 64'(in_ready), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk(tag, 64'({out_man, out_exp, out_denorm, out_zero}),
        64'({x_man, x_exp, x_den, x_zero}));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Six-beat stream with optional clk_en gating in cycles 3..5; records output cycles.
  task automatic ce_run(input bit gate);
    int idx;
    int oidx;
    logic [MW-1:0] frozen;
    idx    = 0;
    oidx   = 0;
    frozen = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      clk_en    = !(gate && c >= 3 && c <= 5);
      out_ready = 1'b1;
      if (idx < 6) drive(beat_man[idx], 8'd60, 5'(idx), 1'b0);
      else in_valid = 1'b0;
      @(negedge clock);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready && clk_en && oidx < 6) begin
        ce_cyc[oidx] = c;
        oidx++;
      end
      if (gate && c == 3) frozen = out_man;
      if (gate && c == 5) chk("ce_freeze", 64'(out_man), 64'(frozen));
    end
    clk_en   = 1'b1;
    in_valid = 1'b0;
    chk("ce_count", 64'(oidx), 64'(6));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int sh;
    int lz;
    logic [MW-1:0] rm;

    sclr      = 1'b1;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    in_man    = '0;
    in_exp    = '0;
    in_q      = '0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({out_man, out_exp, out_denorm, out_zero}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    sclr   = 1'b0;
    mon_en = 1'b1;

    directed("normal",    26'h0200000, 8'd100, 5'd4,  1'b0, 26'h2000000, 8'd96,  1'b0, 1'b0);
    directed("zero",      26'h0000000, 8'd50,  5'd0,  1'b1, 26'h0000000, 8'd0,   1'b0, 1'b1);
    directed("denorm",    26'h0000100, 8'd5,   5'd17, 1'b0, 26'h0001000, 8'd0,   1'b1, 1'b0);
    directed("q_clamp",   26'h0000001, 8'd200, 5'd31, 1'b0, 26'h2000000, 8'd175, 1'b0, 1'b0);
    directed("exp_zero",  26'h0001234, 8'd0,   5'd12, 1'b0, 26'h0001234, 8'd0,   1'b1, 1'b0);
    directed("zero_junk", 26'h3ffffff, 8'd77,  5'd9,  1'b1, 26'h0000000, 8'd0,   1'b0, 1'b1);
    directed("q_eq_exp",  26'h0000010, 8'd21,  5'd21, 1'b0, 26'h1000000, 8'd0,   1'b1, 1'b0);
    directed("exp_one",   26'h0100000, 8'd1,   5'd5,  1'b0, 26'h0100000, 8'd0,   1'b1, 1'b0);
    drain();

    // Backpressure: out_ready low in cycles 3..6.
    for (int i = 0; i < 6; i++) beat_man[i] = MW'($urandom) >> i;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock); #1;
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 6) drive(beat_man[idx], 8'(40 + idx), 5'(idx + 1), 1'b0);
      else in_valid = 1'b0;
      @(negedge clock);
      if (in_valid && in_ready) idx++;
      if (c >= 3 && c <= 6) chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      if (c >= 7 && c <= 11) chk("bp_throughput", 64'(out_valid & out_ready), 64'(1));
    end
    chk("bp_all_accepted", 64'(idx), 64'(6));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Clock-enable gating versus an ungated reference run.
    ce_run(1'b0);
    for (int i = 0; i < 6; i++) ce_ref[i] = ce_cyc[i];
    drain();
    ce_run(1'b1);
    for (int i = 0; i < 6; i++)
      chk("ce_shift", 64'(ce_cyc[i]), 64'(ce_ref[i] + ((ce_ref[i] >= 3) ? 3 : 0)));
    drain();

    // Reset with two beats in flight.
    @(posedge clock); #1;
    out_ready = 1'b0;
    drive(26'h0004000, 8'd90, 5'd11, 1'b0);
    @(posedge clock); #1;
    drive(26'h0000800, 8'd90, 5'd14, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    sclr     = 1'b1;
    @(posedge clock); #1;
    sclr = 1'b0;
    chk("sclr_out_valid", 64'(out_valid), 64'(0));
    chk("sclr_outputs", 64'({out_man, out_exp, out_denorm, out_zero}), 64'(0));
    out_ready = 1'b1;
    directed("post_sclr", 26'h0040000, 8'd30, 5'd7, 1'b0, 26'h2000000, 8'd23, 1'b0, 1'b0);
    drain();

    // Randomized traffic with stalls, gating and rare resets.
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      clk_en    = ($urandom_range(0, 9) != 0);
      sclr      = ($urandom_range(0, 99) == 0);
      sh        = $urandom_range(0, 25);
      rm        = MW'($urandom) >> sh;
      lz        = MW;
      for (int b = MW - 1; b >= 0; b--) begin
        if (rm[b]) begin
          lz = MW - 1 - b;
          break;
        end
      end
      drive(rm,
            ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 30)) : EW'($urandom),
            ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'(lz),
            ($urandom_range(0, 15) == 0));
      in_valid = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    sclr      = 1'b0;
    clk_en    = 1'b1;
    out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
